// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU with a persistent {C,L,F,Z,N} flag
// register, iterative variable shifts, an iterative shift-add multiplier
// and a valid/ready handshake on both sides.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       flags,
  output logic             busy
);

  // Counter must hold both a shift magnitude of 2^SHW and WIDTH.
  localparam int CW = SHW + 1;

  // Bit positions inside the {C,L,F,Z,N} flag register.
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDU = 4'd2,
    OP_ADDC = 4'd3,
    OP_SUB  = 4'd4,
    OP_CMP  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_MOV  = 4'd10,
    OP_LSH  = 4'd11,
    OP_ASH  = 4'd12,
    OP_MUL  = 4'd13
  } op_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;        // shift value, or MUL accumulator
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             left_q, left_d;      // shift direction: 1 = left
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;

  // Single-cycle datapath on the presented operands.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] one_res;
  logic [4:0]       one_flags;
  logic [SHW:0]     amt_raw;
  logic [CW-1:0]    amt_mag;
  logic             is_shift;

  assign amt_raw  = b[SHW:0];
  assign amt_mag  = amt_raw[SHW] ? ('0 - amt_raw) : amt_raw;
  assign is_shift = (op == OP_LSH) || (op == OP_ASH);

  // Result and next flag value for ops that complete on the accept edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    sum_w     = '0;
    one_res   = '0;
    one_flags = flags_q;
    case (op)
      OP_ADD, OP_ADDU: begin
        sum_w         = {1'b0, a} + {1'b0, b};
        one_res       = sum_w[WIDTH-1:0];
        one_flags[FC] = sum_w[WIDTH];
        one_flags[FF] = (op == OP_ADDU) ? sum_w[WIDTH]
                      : (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDC: begin
        sum_w         = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flags_q[FC]};
        one_res       = sum_w[WIDTH-1:0];
        one_flags[FC] = sum_w[WIDTH];
        one_flags[FF] = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum_w         = {1'b0, a} - {1'b0, b};
        one_res       = sum_w[WIDTH-1:0];
        one_flags[FC] = sum_w[WIDTH];   // borrow out of the extended subtract
        one_flags[FF] = (a[WIDTH-1] != b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: begin
        one_flags[FL] = a > b;
        one_flags[FZ] = a == b;
        one_flags[FN] = $signed(a) > $signed(b);
      end
      OP_AND:         one_res = a & b;
      OP_OR:          one_res = a | b;
      OP_XOR:         one_res = a ^ b;
      OP_NOT:         one_res = ~a;
      OP_MOV:         one_res = a;
      OP_LSH, OP_ASH: one_res = a;      // only reached here for a zero amount
      default:        one_res = '0;
    endcase
  end

  // Next-state and next datapath values; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d = op;
            if (op == OP_MUL) begin
              acc_d    = '0;
              mcand_d  = a;
              mplier_d = b;
              cnt_d    = CW'(WIDTH);
              state_d  = S_BUSY;
            end else if (is_shift && (amt_mag != '0)) begin
              acc_d   = a;
              left_d  = !amt_raw[SHW];
              cnt_d   = amt_mag;
              state_d = S_BUSY;
            end else begin
              result_d = one_res;
              flags_d  = one_flags;
              state_d  = S_DONE;
            end
          end
        end
        S_BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (op_q == OP_MUL) begin
            acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end else if (left_q) begin
            acc_d = acc_q << 1;
          end else begin
            acc_d = {(op_q == OP_ASH) & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(1)) begin
            result_d = acc_d;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath, result and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU: the next-generation execution unit for the CR16-style datapath. Generalises the 16-bit combinational ALU to `WIDTH` bits and adds the following:
- A persistent CLFZN flag register, so ADDC genuinely chains carries between operations.
- Variable-amount logical and arithmetic shifts, executed iteratively.
- An iterative shift-add multiplier.
- A valid/ready handshake toward the decode/writeback stages.

## Interface
- `WIDTH`, 16: operand/result width, ≥ 4.
- `SHW`, `$clog2(WIDTH)`: shift-amount field width; the amount is taken from B[SHW:0] as signed (SHW+1)-bit.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort; returns to IDLE, flags untouched.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  high only in IDLE.
- `op`  in  4  operation code, encoded as:
  - 0 NOP, 1 ADD, 2 ADDU, 3 ADDC, 4 SUB, 5 CMP
  - 6 AND, 7 OR, 8 XOR, 9 NOT, 10 MOV
  - 11 LSH, 12 ASH, 13 MUL
  - 14–15 treated as NOP.
- `a`, `b`  in  WIDTH  operands.
- `result`  out  WIDTH  registered result; valid while `out_valid`.
- `out_valid`  out  1  result available; held until `out_ready`.
- `out_ready`  in  1  consumer accepts result.
- `flags`  out  5  {C,L,F,Z,N} flag register.
- `busy`  out  1  high in BUSY state.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Accept:** on an edge with `in_valid & in_ready`, latch `op`, `a`, `b`.
  - Single-cycle ops go to DONE.
  - LSH/ASH with amount magnitude n > 0 go to BUSY with count = n; n = 0 goes straight to DONE.
  - MUL goes to BUSY with count = WIDTH.
- **BUSY:** each cycle:
  - LSH/ASH shift one bit.
  - MUL performs one shift-add step: if multiplier LSB = 1, acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1.
  - Count decrements each cycle; on the edge where count reaches 0, go to DONE.
- **DONE:** `out_valid` = 1. On an edge with `out_ready` = 1, go to IDLE.
- **Arithmetic:** modulo 2^WIDTH.
  - ADD/ADDU: C = carry out of `a`+`b`.
  - ADDC: result and C from `a`+`b`+C_reg.
  - SUB: result = `a`−`b`; C = borrow (`a` < `b` unsigned).
  - F = signed overflow for ADD, ADDC and SUB.
  - ADDU sets F = C.
- **CMP:** `result` = 0; L = (`a` > `b` unsigned), Z = (`a` == `b`), N = (`a` > `b` signed).
- **Logic:** NOT is bitwise ~`a`. MOV passes `a`.
- **Shifts:** positive amount shifts left, negative shifts right.
  - LSH fills with zeros.
  - ASH left fills zeros; ASH right replicates `a`[WIDTH−1].
  - Magnitude ≥ WIDTH (only −WIDTH reachable) gives 0 for LSH, or all copies of the sign bit for ASH right.
- **MUL:** unsigned; result is the low WIDTH bits of the product.
- **Flag writes:** performed on the same edge that enters DONE.
  - ADD/ADDU/ADDC/SUB write C and F only.
  - CMP writes L, Z, N only.
  - All other ops leave flags unchanged.
- **flush:** forces IDLE from any state and discards the op. An in-flight op never writes flags.
  - `flush` has priority over accept and over `out_ready`.
- **NOP/unused op:** completes like a single-cycle op with `result` = 0; flags unchanged.

## Timing
- **Reset (async assert, sync release):**
  - state IDLE; `result` = 0; `flags` = 0; `out_valid` = 0.
  - `in_ready` = 1; `busy` = 0.
  - Reset mid-operation abandons the op immediately.
- **Single-cycle op:** accepted at edge k; `out_valid` high from edge k+1.
- **Shift by n:** `out_valid` from edge k+1+n.
- **MUL:** `out_valid` from edge k+1+WIDTH.
- `flags` reflect the completed op from the same edge `out_valid` rises.
- `result` is stable while `out_valid` is high and `out_ready` is low.
- **Throughput:** at most one op per 2 cycles, since `in_ready` is low in DONE even when `out_ready` = 1.
- `in_ready` and `busy` are decoded from registered state; no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-MUL → outputs go to reset values without a clock edge. After release, `in_ready` = 1 and `flags` = 0.
- **Overflow and carry chain:**
  - ADD 0x7FFF+0x0001 → `result` 0x8000, C = 0, F = 1, `out_valid` 1 cycle after accept.
  - ADDU 0xFFFF+0x0001 → 0x0000, C = 1.
  - Then ADDC 0x0001+0x0002 → 0x0004, C = 0.
- **Shifts:**
  - LSH `a` = 0x0001, `b` = 5 → 0x0020 at latency 6.
  - LSH `a` = 0x8000, `b` = 0x001D (−3) → 0x1000.
  - ASH same operands → 0xF000.
  - LSH `b` = 0x0010 (−16) → 0x0000 at latency 17.
- **MUL:** 0x0123 × 0x0010 → 0x1230 at latency 17. Then 0xFFFF × 0xFFFF → 0x0001. Flags unchanged by both.
- **CMP then logic:**
  - CMP 0xFFFF vs 0x0001 → L = 1, Z = 0, N = 0, C/F retained.
  - Subsequent AND leaves all five flags unchanged.
- **Handshake and flush:**
  - Hold `out_ready` = 0 for 5 cycles → `result` stable, `in_ready` stays 0.
  - `flush` during BUSY of a SUB-free MUL → IDLE next cycle, no `out_valid`, `flags` unchanged.
